checkpoint_renamer: RTL

//  Parametrised register renamer with multi-cycle post-reset init, in-order

---
 rtl/checkpoint_renamer_pkg.sv | 28 ++
 rtl/checkpoint_renamer_if.sv | 61 ++++++
 rtl/checkpoint_renamer_free_list.sv | 68 ++++++
 rtl/checkpoint_renamer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/checkpoint_renamer_pkg.sv
// Shared types and helpers for the checkpoint register renamer.
//  - init_state_t : post-reset initialisation state (INIT_ST while the spec
//                   table and free list are being seeded, RUN_ST afterwards)
//  - idx_width    : address width for an n-entry structure, never below 1
//  - max_int      : larger of two integers, used to size the init sequence
package checkpoint_renamer_pkg;

    localparam int DEF_ARCH_REGS     = 32;
    localparam int DEF_PHYS_REGS     = 64;
    localparam int DEF_READ_PORTS    = 2;
    localparam int DEF_NUM_WB_GROUPS = 2;
    localparam int DEF_MAX_IDS       = 8;
    localparam int DEF_NUM_CKPT      = 4;

    typedef enum logic {
        INIT_ST = 1'b0,
        RUN_ST  = 1'b1
    } init_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/checkpoint_renamer_if.sv
// Decode/rename/recovery/retire bundle of the checkpoint register renamer.
//  master : decode + control side (drives decode, restore, release, retire)
//  slave  : the renamer (drives init_done, rename_ready and renamed operands)
//  dec_valid/dec_uses_rd/dec_rd/dec_rd_wb_group/dec_rs/dec_id/dec_ckpt_req
//                       decode instruction presented for renaming
//  init_done/rename_ready/phys_rs/rs_wb_group/phys_rd/ckpt_id
//                       renamer status and combinational rename results
//  restore_valid/restore_id  mispredict recovery to a checkpoint slot
//  ckpt_release              oldest checkpointed branch retired
//  retire_valid/retire_id/retire_discard  instruction with rd leaving pipeline
interface checkpoint_renamer_if
    import checkpoint_renamer_pkg::*;
#(
    parameter int ARCH_REGS     = DEF_ARCH_REGS,
    parameter int PHYS_REGS     = DEF_PHYS_REGS,
    parameter int READ_PORTS    = DEF_READ_PORTS,
    parameter int NUM_WB_GROUPS = DEF_NUM_WB_GROUPS,
    parameter int MAX_IDS       = DEF_MAX_IDS,
    parameter int NUM_CKPT      = DEF_NUM_CKPT
);
    localparam int AW = idx_width(ARCH_REGS);
    localparam int PW = idx_width(PHYS_REGS);
    localparam int GW = idx_width(NUM_WB_GROUPS);
    localparam int IW = idx_width(MAX_IDS);
    localparam int CW = idx_width(NUM_CKPT);

    logic                           init_done;
    logic                           dec_valid;
    logic                           dec_uses_rd;
    logic [AW-1:0]                  dec_rd;
    logic [GW-1:0]                  dec_rd_wb_group;
    logic [READ_PORTS-1:0][AW-1:0]  dec_rs;
    logic [IW-1:0]                  dec_id;
    logic                           dec_ckpt_req;
    logic                           rename_ready;
    logic [READ_PORTS-1:0][PW-1:0]  phys_rs;
    logic [READ_PORTS-1:0][GW-1:0]  rs_wb_group;
    logic [PW-1:0]                  phys_rd;
    logic [CW-1:0]                  ckpt_id;
    logic                           restore_valid;
    logic [CW-1:0]                  restore_id;
    logic                           ckpt_release;
    logic                           retire_valid;
    logic [IW-1:0]                  retire_id;
    logic                           retire_discard;

    modport master (
        output dec_valid, dec_uses_rd, dec_rd, dec_rd_wb_group, dec_rs, dec_id,
               dec_ckpt_req, restore_valid, restore_id, ckpt_release,
               retire_valid, retire_id, retire_discard,
        input  init_done, rename_ready, phys_rs, rs_wb_group, phys_rd, ckpt_id
    );

    modport slave (
        input  dec_valid, dec_uses_rd, dec_rd, dec_rd_wb_group, dec_rs, dec_id,
               dec_ckpt_req, restore_valid, restore_id, ckpt_release,
               retire_valid, retire_id, retire_discard,
        output init_done, rename_ready, phys_rs, rs_wb_group, phys_rd, ckpt_id
    );

endinterface

// File: rtl/checkpoint_renamer_free_list.sv
// Circular FIFO of free physical register addresses.
//  clk, rst       clock, synchronous active-high reset (empties the list)
//  push/push_data append an address at the tail
//  pop            advance the head (pop_data is the current head entry)
//  empty          no free address available
//  head_ptr       current head pointer (with wrap bit) for checkpointing
//  load_head/load_head_ptr  rewind the head to a saved snapshot
// DEPTH must be a power of two; pointers carry one extra wrap bit so a full
// list (count == DEPTH) is distinguishable from an empty one.
module checkpoint_renamer_free_list
    import checkpoint_renamer_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int PW    = 6,
    localparam int PTRW = idx_width(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PW-1:0]   push_data,
    input  logic            pop,
    output logic [PW-1:0]   pop_data,
    output logic            empty,
    output logic [PTRW-1:0] head_ptr,
    input  logic            load_head,
    input  logic [PTRW-1:0] load_head_ptr
);

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] head_q;
    logic [PTRW-1:0] tail_q;
    logic [PTRW-1:0] count;

    assign count    = tail_q - head_q;
    assign empty    = (count == '0);
    assign head_ptr = head_q;
    assign pop_data = mem[head_q[PTRW-2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTRW'(1);
            end
            // A restore rewinds the head; entries popped on the wrong path
            // become free again simply by being back inside head..tail.
            if (load_head) begin
                head_q <= load_head_ptr;
            end else if (pop) begin
                head_q <= head_q + PTRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q[PTRW-2:0]] <= push_data;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= PTRW'(DEPTH));

endmodule

// File: rtl/checkpoint_renamer.sv
// Register renamer with checkpointed speculative map table.
//  clk, rst   clock, synchronous active-high reset
//  bus        checkpoint_renamer_if.slave: decode in, renamed operands out,
//             checkpoint restore/release and retire inputs
// After reset a multi-cycle init maps arch i -> phys i (group 0) and fills
// the free list with ARCH_REGS..PHYS_REGS-1. Renaming then reads sources from
// the current map, pops a free phys reg for rd and records the previous
// mapping per instruction id so it can be freed when that id retires.
// A branch snapshots the updated map and free-list head into a checkpoint
// slot; a restore reloads both in one cycle.
module checkpoint_renamer
    import checkpoint_renamer_pkg::*;
#(
    parameter int ARCH_REGS     = DEF_ARCH_REGS,
    parameter int PHYS_REGS     = DEF_PHYS_REGS,
    parameter int READ_PORTS    = DEF_READ_PORTS,
    parameter int NUM_WB_GROUPS = DEF_NUM_WB_GROUPS,
    parameter int MAX_IDS       = DEF_MAX_IDS,
    parameter int NUM_CKPT      = DEF_NUM_CKPT,
    parameter int RENAME_ZERO   = 0
) (
    input logic                 clk,
    input logic                 rst,
    checkpoint_renamer_if.slave bus
);

    localparam int AW          = idx_width(ARCH_REGS);
    localparam int PW          = idx_width(PHYS_REGS);
    localparam int GW          = idx_width(NUM_WB_GROUPS);
    localparam int CW          = idx_width(NUM_CKPT);
    localparam int FREE_DEPTH  = PHYS_REGS - ARCH_REGS;
    localparam int FPW         = idx_width(FREE_DEPTH) + 1;
    localparam int INIT_CYCLES = max_int(ARCH_REGS, FREE_DEPTH);
    localparam int ICW         = idx_width(INIT_CYCLES);

    typedef struct packed {
        logic [PW-1:0] phys;
        logic [GW-1:0] group;
    } map_t;

    init_state_t   state_q, state_d;
    logic [ICW-1:0] init_cnt_q;
    logic          init_active;
    logic          init_done;
    logic          init_spec_we;
    logic          init_push;

    map_t          spec_q [ARCH_REGS];
    map_t          spec_d [ARCH_REGS];
    map_t          ckpt_tbl_q [NUM_CKPT][ARCH_REGS];
    logic [FPW-1:0] ckpt_head_q [NUM_CKPT];
    logic [CW:0]   alloc_ptr_q, release_ptr_q;
    logic [CW:0]   ckpt_live;
    logic          ckpt_full;
    logic [CW-1:0] restore_off;

    // Only the previous phys is needed at retire, so the group is not kept.
    logic [PW-1:0] inuse_q [MAX_IDS];

    logic          rename_ready, fire, rd_rename, take_ckpt, restore_apply;
    logic          retire_push;
    logic [READ_PORTS-1:0][PW-1:0] rs_phys;
    logic [READ_PORTS-1:0][GW-1:0] rs_group;

    logic          fl_push, fl_empty;
    logic [PW-1:0] fl_push_data, fl_head_data;
    logic [FPW-1:0] fl_head_ptr, fl_head_after;

    // ---------------- init FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_ST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT_ST && init_cnt_q == ICW'(INIT_CYCLES - 1)) begin
            state_d = RUN_ST;
        end
    end

    always_comb begin
        init_active  = (state_q == INIT_ST);
        init_done    = (state_q == RUN_ST);
        init_spec_we = init_active && (int'(init_cnt_q) < ARCH_REGS);
        init_push    = init_active && (int'(init_cnt_q) < FREE_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else if (init_active) begin
            init_cnt_q <= init_cnt_q + ICW'(1);
        end
    end

    // ---------------- handshake ----------------
    assign ckpt_live     = alloc_ptr_q - release_ptr_q;
    assign ckpt_full     = (ckpt_live == (CW+1)'(NUM_CKPT));
    assign rename_ready  = init_done && !bus.restore_valid && !fl_empty
                           && !(bus.dec_ckpt_req && ckpt_full);
    assign fire          = bus.dec_valid && rename_ready;
    assign rd_rename     = fire && bus.dec_uses_rd
                           && ((RENAME_ZERO != 0) || (bus.dec_rd != '0));
    assign take_ckpt     = fire && bus.dec_ckpt_req;
    assign restore_apply = init_done && bus.restore_valid;
    assign retire_push   = init_done && bus.retire_valid && !bus.retire_discard;
    // Offset of the restored slot from the oldest live slot.
    assign restore_off   = bus.restore_id - release_ptr_q[CW-1:0];
    assign fl_head_after = fl_head_ptr + FPW'(rd_rename);

    assign bus.init_done    = init_done;
    assign bus.rename_ready = rename_ready;
    assign bus.phys_rd      = rd_rename ? fl_head_data : '0;
    assign bus.ckpt_id      = alloc_ptr_q[CW-1:0];
    assign bus.phys_rs      = rs_phys;
    assign bus.rs_wb_group  = rs_group;

    // Source lookups see the table before this cycle's rd update.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            rs_phys[i]  = spec_q[bus.dec_rs[i]].phys;
            rs_group[i] = spec_q[bus.dec_rs[i]].group;
            if (RENAME_ZERO == 0 && bus.dec_rs[i] == '0) begin
                rs_phys[i]  = '0;
                rs_group[i] = '0;
            end
        end
    end

    // ---------------- speculative map table ----------------
    always_comb begin
        spec_d = spec_q;
        if (init_spec_we) begin
            spec_d[AW'(init_cnt_q)] = '{phys: PW'(init_cnt_q), group: '0};
        end
        if (rd_rename) begin
            spec_d[bus.dec_rd] = '{phys: fl_head_data, group: bus.dec_rd_wb_group};
        end
        if (restore_apply) begin
            spec_d = ckpt_tbl_q[bus.restore_id];
        end
    end

    always_ff @(posedge clk) begin
        spec_q <= spec_d;
    end

    // Checkpoints capture the map including this branch's own rd write.
    always_ff @(posedge clk) begin
        if (take_ckpt) begin
            ckpt_tbl_q[alloc_ptr_q[CW-1:0]]  <= spec_d;
            ckpt_head_q[alloc_ptr_q[CW-1:0]] <= fl_head_after;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q   <= '0;
            release_ptr_q <= '0;
        end else begin
            if (bus.ckpt_release) begin
                release_ptr_q <= release_ptr_q + (CW+1)'(1);
            end
            if (restore_apply) begin
                alloc_ptr_q <= release_ptr_q + {1'b0, restore_off} + (CW+1)'(1);
            end else if (take_ckpt) begin
                alloc_ptr_q <= alloc_ptr_q + (CW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_rename) begin
            inuse_q[bus.dec_id] <= spec_q[bus.dec_rd].phys;
        end
    end

    // ---------------- free list ----------------
    always_comb begin
        fl_push      = init_push || retire_push;
        fl_push_data = init_active ? (PW'(ARCH_REGS) + PW'(init_cnt_q))
                                   : inuse_q[bus.retire_id];
    end

    checkpoint_renamer_free_list #(
        .DEPTH (FREE_DEPTH),
        .PW    (PW)
    ) u_free_list (
        .clk           (clk),
        .rst           (rst),
        .push          (fl_push),
        .push_data     (fl_push_data),
        .pop           (rd_rename),
        .pop_data      (fl_head_data),
        .empty         (fl_empty),
        .head_ptr      (fl_head_ptr),
        .load_head     (restore_apply),
        .load_head_ptr (ckpt_head_q[bus.restore_id])
    );

    a_restore_live: assert property (@(posedge clk) disable iff (rst)
        restore_apply |-> ({1'b0, restore_off} < ckpt_live));
    a_release_live: assert property (@(posedge clk) disable iff (rst)
        bus.ckpt_release |-> (ckpt_live != '0));

endmodule
